// File: rtl/cacheline_adaptor_if.sv
// Bundle of the cache-side and memory-side signals of the cacheline adaptor.
// Signal directions are named from the adaptor's point of view.
interface cacheline_adaptor_if #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
);
    logic [s_line-1:0]  line_i;
    logic [s_line-1:0]  line_o;
    logic [31:0]        address_i;
    logic               read_i;
    logic               write_i;
    logic               resp_o;
    logic [s_burst-1:0] burst_i;
    logic [s_burst-1:0] burst_o;
    logic [31:0]        address_o;
    logic               read_o;
    logic               write_o;
    logic               resp_i;

    modport slave (
        input  line_i, address_i, read_i, write_i, burst_i, resp_i,
        output line_o, resp_o, burst_o, address_o, read_o, write_o
    );

    modport master (
        output line_i, address_i, read_i, write_i, burst_i, resp_i,
        input  line_o, resp_o, burst_o, address_o, read_o, write_o
    );
endinterface

// File: rtl/cacheline_adaptor.sv
// Converts whole cache-line reads/writes into bursts of memory beats and back.
// Every output is a register so memory and cache see glitch-free signals.
module cacheline_adaptor #(
    parameter int s_line  = 256,
    parameter int s_burst = 64
) (
    input logic                  clk,
    input logic                  rst,
    cacheline_adaptor_if.slave   bus
);
    localparam int BEATS = s_line / s_burst;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [s_line-1:0]  lineBuf_q, lineBuf_d;
    logic [s_line-1:0]  line_q, line_d;
    logic [31:0]        addr_q, addr_d;
    logic [s_burst-1:0] burst_q, burst_d;
    logic               read_q, read_d;
    logic               write_q, write_d;
    logic               resp_q, resp_d;
    logic [CW-1:0]      cntNext;
    logic [31:0]        baseNext;
    logic [31:0]        baseCur;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lineBuf_q <= '0;
            line_q    <= '0;
            addr_q    <= '0;
            burst_q   <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            resp_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lineBuf_q <= lineBuf_d;
            line_q    <= line_d;
            addr_q    <= addr_d;
            burst_q   <= burst_d;
            read_q    <= read_d;
            write_q   <= write_d;
            resp_q    <= resp_d;
        end
    end

    // burst_o is registered, so it is loaded with the slice for the beat after the one being accepted
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        lineBuf_d = lineBuf_q;
        line_d    = line_q;
        addr_d    = addr_q;
        burst_d   = burst_q;
        read_d    = read_q;
        write_d   = write_q;
        resp_d    = 1'b0;
        cntNext   = cnt_q + 1'b1;
        baseNext  = 32'(cntNext) * 32'(s_burst);
        baseCur   = 32'(cnt_q) * 32'(s_burst);

        case (state_q)
            IDLE: begin
                if (bus.write_i) begin
                    lineBuf_d = bus.line_i;
                    addr_d    = bus.address_i;
                    cnt_d     = '0;
                    burst_d   = bus.line_i[s_burst-1:0];
                    write_d   = 1'b1;
                    state_d   = WRITE;
                end else if (bus.read_i) begin
                    addr_d  = bus.address_i;
                    cnt_d   = '0;
                    read_d  = 1'b1;
                    state_d = READ;
                end
            end
            READ: begin
                if (bus.resp_i) begin
                    line_d[baseCur +: s_burst] = bus.burst_i;
                    if (cnt_q == LAST) begin
                        read_d  = 1'b0;
                        resp_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d = cntNext;
                    end
                end
            end
            WRITE: begin
                if (bus.resp_i) begin
                    if (cnt_q == LAST) begin
                        write_d = 1'b0;
                        burst_d = '0;
                        resp_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = DONE;
                    end else begin
                        cnt_d   = cntNext;
                        burst_d = lineBuf_q[baseNext +: s_burst];
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.line_o    = line_q;
    assign bus.address_o = addr_q;
    assign bus.burst_o   = burst_q;
    assign bus.read_o    = read_q;
    assign bus.write_o   = write_q;
    assign bus.resp_o    = resp_q;
endmodule
